framebuffer_ctrl: RTL and testbench

FRAMEBUFFER_CTRL -- requirements
Module: framebuffer_ctrl

---
 rtl/fb_pkg.sv | 30 +++
 rtl/fb_ram.sv | 46 ++++
 rtl/framebuffer_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_framebuffer_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and state encodings for the framebuffer controller.
//   WIDTH, HEIGHT : default screen geometry in pixels
//   PIXELS        : WIDTH*HEIGHT, the number of RAM words
//   ADDR_W        : RAM address width (covers PIXELS)
//   CW            : colour width in bits
//   clr_state_e   : clear engine states
//   scan_state_e  : raster read-out states
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int PIXELS = WIDTH * HEIGHT;   // 19200
    localparam int ADDR_W = 15;
    localparam int CW     = 3;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } clr_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } scan_state_e;

endpackage

// File: rtl/fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
// Simple dual-port pixel store: one write port, one synchronous read port.
// A read and a write to the same address in the same cycle return the old
// contents (read-before-write).
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, data appears on rdata_o one cycle later
//   rdata_o  : registered read data
// Contents come up as all zero from device configuration; they are never
// cleared by reset.
// -----------------------------------------------------------------------------
module fb_ram
    import fb_pkg::*;
#(
    parameter int DEPTH = PIXELS,
    parameter int AW    = ADDR_W,
    parameter int DW    = CW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // NOTE: the storage array has no reset branch; a reset loop over every
    // word cannot map onto block RAM and would turn it into flops.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // Both updates share one edge, so a colliding read sees the old word.
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer_ctrl.sv
// -----------------------------------------------------------------------------
// framebuffer_ctrl
// Pixel framebuffer with a single-pixel plot path, a full-screen clear engine
// and a raster read-out engine that runs concurrently with either writer.
// Ports:
//   clk          : clock, rising edge
//   resetn       : asynchronous reset, active HIGH despite the name
//   plot         : write request for (x, y, colour), one pixel per cycle
//   x, y         : plot coordinates; out-of-range plots are dropped
//   colour       : plot colour
//   clear_req    : start a full-screen fill with clear_colour
//   clear_colour : fill colour, sampled with clear_req
//   busy         : clear in progress (plots are dropped meanwhile)
//   scan_start   : start one raster read-out
//   scan_busy    : read-out in progress
//   pix_valid    : pix_x / pix_y / pix_colour valid this cycle
//   pix_x, pix_y : coordinates of the presented pixel
//   pix_colour   : stored colour of the presented pixel
//   frame_done   : one-cycle pulse alongside the last pixel of a read-out
//   drop_cnt     : saturating count of rejected plots
// -----------------------------------------------------------------------------
module framebuffer_ctrl
    import fb_pkg::*;
#(
    parameter int WIDTH  = fb_pkg::WIDTH,
    parameter int HEIGHT = fb_pkg::HEIGHT,
    parameter int CW     = fb_pkg::CW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          plot,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [CW-1:0] colour,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_colour,
    output logic          busy,
    input  logic          scan_start,
    output logic          scan_busy,
    output logic          pix_valid,
    output logic [9:0]    pix_x,
    output logic [9:0]    pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          frame_done,
    output logic [7:0]    drop_cnt
);

    localparam int                NPIX   = WIDTH * HEIGHT;
    localparam logic [9:0]        W_LIM  = 10'(WIDTH);
    localparam logic [9:0]        H_LIM  = 10'(HEIGHT);
    localparam logic [9:0]        X_LAST = 10'(WIDTH - 1);
    localparam logic [9:0]        Y_LAST = 10'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

    // y*WIDTH + x. For the 160-pixel screen this is two shifts and adds;
    // other widths fall back to a constant multiply.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] px,
                                                   input logic [9:0] py);
        logic [ADDR_W-1:0] xe;
        logic [ADDR_W-1:0] ye;
        xe = ADDR_W'(px);
        ye = ADDR_W'(py);
        if (WIDTH == 160) begin
            return (ye << 7) + (ye << 5) + xe;
        end
        return ye * ADDR_W'(WIDTH) + xe;
    endfunction

    // ---------------------------------------------------------------- state
    clr_state_e        clr_q,   clr_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [CW-1:0]     ccol_q,  ccol_d;

    scan_state_e       scan_q,  scan_d;
    logic [9:0]        sx_q,    sx_d;
    logic [9:0]        sy_q,    sy_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;

    logic              pix_valid_q, pix_valid_d;
    logic [9:0]        pix_x_q,     pix_x_d;
    logic [9:0]        pix_y_q,     pix_y_d;
    logic [7:0]        drop_q,      drop_d;

    logic              plot_ok;
    logic              plot_drop;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [CW-1:0]     ram_wdata;
    logic [CW-1:0]     ram_rdata;

    // ---------------------------------------------------------- plot path
    assign busy      = (clr_q == C_RUN);
    assign plot_ok   = plot && !busy && (x < W_LIM) && (y < H_LIM);
    assign plot_drop = plot && !plot_ok;

    assign drop_d = (plot_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    // --------------------------------------------------------- clear engine
    always_comb begin
        // NOTE: every output of this block is defaulted before the case so
        // no path leaves a value unassigned (which would infer a latch).
        clr_d   = clr_q;
        caddr_d = caddr_q;
        ccol_d  = ccol_q;
        case (clr_q)
            C_IDLE: begin
                if (clear_req) begin
                    ccol_d  = clear_colour;
                    caddr_d = '0;
                    clr_d   = C_RUN;
                end
            end
            C_RUN: begin
                if (caddr_q == A_LAST) begin
                    clr_d = C_IDLE;
                end else begin
                    caddr_d = caddr_q + A_ONE;
                end
            end
            default: clr_d = C_IDLE;
        endcase
    end

    // Clear owns the write port for its whole run; plots are dropped then.
    always_comb begin
        if (clr_q == C_RUN) begin
            ram_we    = 1'b1;
            ram_waddr = caddr_q;
            ram_wdata = ccol_q;
        end else begin
            ram_we    = plot_ok;
            ram_waddr = pix_addr(x, y);
            ram_wdata = colour;
        end
    end

    // ---------------------------------------------------------- scan engine
    always_comb begin
        scan_d      = scan_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        saddr_d     = saddr_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        case (scan_q)
            S_IDLE: begin
                if (scan_start) begin
                    sx_d    = '0;
                    sy_d    = '0;
                    saddr_d = '0;
                    scan_d  = S_RUN;
                end
            end
            S_RUN: begin
                // The address issued now is read at this edge, so its
                // coordinates travel one stage alongside the RAM output.
                pix_valid_d = 1'b1;
                pix_x_d     = sx_q;
                pix_y_d     = sy_q;
                if (sx_q == X_LAST) begin
                    sx_d = '0;
                    if (sy_q == Y_LAST) begin
                        saddr_d = '0;
                        scan_d  = S_FLUSH;
                    end else begin
                        sy_d    = sy_q + 10'd1;
                        saddr_d = saddr_q + A_ONE;
                    end
                end else begin
                    sx_d    = sx_q + 10'd1;
                    saddr_d = saddr_q + A_ONE;
                end
            end
            // Presents the last pixel; no new address is issued.
            S_FLUSH: scan_d = S_IDLE;
            default: scan_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            clr_q       <= C_IDLE;
            caddr_q     <= '0;
            ccol_q      <= '0;
            scan_q      <= S_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            saddr_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            drop_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge value of the others, independent of statement order.
            clr_q       <= clr_d;
            caddr_q     <= caddr_d;
            ccol_q      <= ccol_d;
            scan_q      <= scan_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            saddr_q     <= saddr_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            drop_q      <= drop_d;
        end
    end

    fb_ram #(
        .DEPTH (NPIX),
        .AW    (ADDR_W),
        .DW    (CW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (saddr_q),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------- outputs
    assign scan_busy  = (scan_q != S_IDLE);
    assign frame_done = (scan_q == S_FLUSH);
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    // The RAM output register has no reset; gate it so the presented colour
    // is zero whenever no pixel is valid, including straight after reset.
    assign pix_colour = pix_valid_q ? ram_rdata : '0;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_ctrl
// Directed bench for framebuffer_ctrl at 160x120, 3-bit colour. A reference
// array holds the expected RAM contents; plot vectors come from a table and
// the clear / scan / reset corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_framebuffer_ctrl;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = 19200;

    logic       clk = 1'b0;
    logic       resetn;
    logic       plot;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] colour;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       busy;
    logic       scan_start;
    logic       scan_busy;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] pix_colour;
    logic       frame_done;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    framebuffer_ctrl #(
        .WIDTH  (W),
        .HEIGHT (H),
        .CW     (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .busy         (busy),
        .scan_start   (scan_start),
        .scan_busy    (scan_busy),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_colour   (pix_colour),
        .frame_done   (frame_done),
        .drop_cnt     (drop_cnt)
    );

    int         errors = 0;
    int         checks = 0;
    logic [2:0] model [NPIX];

    typedef struct {
        logic       plot;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        logic       exp_wr;
        logic [7:0] exp_drop;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete read-out compared against the model. With extras set, the
    // bench plots (7,0) colour 1 in the very cycle address 7 is read, and
    // re-pulses scan_start mid-frame and during the frame_done cycle.
    task automatic run_scan(input string tag, input bit extras,
                            input logic [2:0] exp7);
        int         pix;
        int         vcnt;
        int         fdcnt;
        int         gaps;
        int         xerr;
        int         cerr;
        int         idle_bad;
        bit         started;
        bit         done;
        logic [9:0] fdx;
        logic [9:0] fdy;
        logic [2:0] pres7;
        pix = 0; vcnt = 0; fdcnt = 0; gaps = 0; xerr = 0; cerr = 0;
        idle_bad = 0; started = 0; done = 0;
        fdx = '0; fdy = '0; pres7 = 3'bxxx;

        x = 10'd7; y = 10'd0; colour = 3'd1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check({tag, "_scan_busy_on_start"}, scan_busy, 1);

        for (int i = 1; i <= NPIX + 100 && !done; i++) begin
            tick();
            if (pix_valid) begin
                started = 1;
                vcnt++;
                if (pix < NPIX) begin
                    if (pix_x !== 10'(pix % W) || pix_y !== 10'(pix / W)) xerr++;
                    if (pix_colour !== model[pix]) cerr++;
                    if (pix == 7) pres7 = pix_colour;
                end else begin
                    xerr++;
                end
                pix++;
            end else if (started) begin
                gaps++;
            end
            plot       = extras && (i == 7);
            scan_start = extras && (i == 1000);
            if (frame_done) begin
                fdcnt++;
                fdx  = pix_x;
                fdy  = pix_y;
                done = 1;
                if (extras) scan_start = 1'b1;
            end
        end
        check({tag, "_frame_done_seen"}, done, 1);
        tick();
        scan_start = 1'b0;
        plot       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (scan_busy || pix_valid || frame_done) idle_bad++;
            tick();
        end

        check({tag, "_valid_count"},      vcnt,     NPIX);
        check({tag, "_frame_done_count"}, fdcnt,    1);
        check({tag, "_frame_done_x"},     fdx,      W - 1);
        check({tag, "_frame_done_y"},     fdy,      H - 1);
        check({tag, "_valid_gaps"},       gaps,     0);
        check({tag, "_coord_errors"},     xerr,     0);
        check({tag, "_colour_errors"},    cerr,     0);
        check({tag, "_pixel_7_0"},        pres7,    exp7);
        check({tag, "_idle_after"},       idle_bad, 0);
    endtask

    initial begin
        int cnt;

        // plot, x, y, colour, RAM written?, drop_cnt after the edge
        vecs[0] = '{1'b1, 10'd5,    10'd3,    3'd5, 1'b1, 8'd0};
        vecs[1] = '{1'b1, 10'd160,  10'd0,    3'd7, 1'b0, 8'd1};
        vecs[2] = '{1'b1, 10'd0,    10'd120,  3'd7, 1'b0, 8'd2};
        vecs[3] = '{1'b1, 10'd1023, 10'd1023, 3'd7, 1'b0, 8'd3};
        vecs[4] = '{1'b1, 10'd159,  10'd119,  3'd3, 1'b1, 8'd3};
        vecs[5] = '{1'b0, 10'd1023, 10'd0,    3'd7, 1'b0, 8'd3};
        vecs[6] = '{1'b1, 10'd0,    10'd0,    3'd1, 1'b1, 8'd3};
        vecs[7] = '{1'b1, 10'd159,  10'd0,    3'd4, 1'b1, 8'd3};
        vecs[8] = '{1'b1, 10'd0,    10'd119,  3'd7, 1'b1, 8'd3};

        for (int i = 0; i < NPIX; i++) model[i] = 3'd0;

        resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
        clear_req = 1'b0; clear_colour = '0; scan_start = 1'b0;

        // ---------------- reset state (asynchronous, before any clock edge)
        #1 resetn = 1'b1;
        #1;
        check("rst_busy",       busy,       0);
        check("rst_scan_busy",  scan_busy,  0);
        check("rst_pix_valid",  pix_valid,  0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pix_x",      pix_x,      0);
        check("rst_pix_y",      pix_y,      0);
        check("rst_pix_colour", pix_colour, 0);
        check("rst_drop_cnt",   drop_cnt,   0);
        tick();
        tick();
        resetn = 1'b0;
        tick();

        // ---------------- full clear to colour 2
        clear_colour = 3'd2;
        clear_req    = 1'b1;
        tick();
        clear_req = 1'b0;
        x = 10'd10; y = 10'd10; colour = 3'd5;
        cnt = 0;
        while (busy && cnt < 20000) begin
            cnt++;
            if (cnt == 101) check("clr_plot_dropped", drop_cnt, 1);
            plot         = (cnt == 100);
            clear_req    = (cnt == 200);
            clear_colour = (cnt == 200) ? 3'd7 : 3'd2;
            tick();
        end
        plot = 1'b0; clear_req = 1'b0;
        check("clr_busy_cycles", cnt, NPIX);
        for (int i = 0; i < NPIX; i++) model[i] = 3'd2;

        // ---------------- partial clear to colour 6, reset at address 5000
        clear_colour = 3'd6;
        clear_req    = 1'b1;
        tick();
        clear_req = 1'b0;
        check("pclr_busy_on", busy, 1);
        repeat (5000) tick();
        resetn = 1'b1;
        #1;
        check("pclr_busy_async",    busy,     0);
        check("pclr_drop_cleared",  drop_cnt, 0);
        @(posedge clk);
        #1;
        check("pclr_busy_next_edge", busy, 0);
        resetn = 1'b0;
        tick();
        for (int i = 0; i < 5000; i++) model[i] = 3'd6;

        // ---------------- plot vectors
        for (int i = 0; i < 9; i++) begin
            plot   = vecs[i].plot;
            x      = vecs[i].x;
            y      = vecs[i].y;
            colour = vecs[i].c;
            tick();
            check($sformatf("vec%0d_drop_cnt", i), drop_cnt, vecs[i].exp_drop);
            if (vecs[i].exp_wr) model[vecs[i].y * W + vecs[i].x] = vecs[i].c;
        end
        plot = 1'b0;

        // ---------------- scan with concurrent plot and ignored restarts
        run_scan("scanA", 1'b1, 3'd6);
        model[7] = 3'd1;
        check("scanA_drop_unchanged", drop_cnt, 3);

        // ---------------- scan showing the concurrent write landed
        run_scan("scanB", 1'b0, 3'd1);

        // ---------------- drop counter saturation
        x = 10'd200; y = 10'd0; colour = 3'd7;
        for (int n = 1; n <= 300; n++) begin
            plot = 1'b1;
            tick();
            if (n == 251) check("drop_254", drop_cnt, 254);
            if (n == 252) check("drop_255", drop_cnt, 255);
        end
        plot = 1'b0;
        check("drop_saturated", drop_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
